// File: rtl/gpu_reg_pkg.sv
// -----------------------------------------------------------------------------
// gpu_reg_pkg
// Shared register-file geometry for one warp: bank count, row width, data width,
// helpers that split a register number into bank and row fields, and the
// command record that the bank arbiter issues to each gpu_bank instance.
// No ports (package).
// -----------------------------------------------------------------------------
package gpu_reg_pkg;

    localparam int NUM_BANKS = 4;
    localparam int ROW_W     = 3;
    localparam int DATA_W    = 64;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int REG_W     = ROW_W + BANK_W;

    // One registered command per bank per cycle.
    typedef struct packed {
        logic              read;
        logic              write;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] wdata;
    } bank_cmd_t;

    // Low bits of the register number pick the bank, so consecutive registers
    // land in different banks and parallel operand reads rarely collide.
    function automatic logic [BANK_W-1:0] reg_bank(input logic [REG_W-1:0] regNum);
        return regNum[BANK_W-1:0];
    endfunction

    function automatic logic [ROW_W-1:0] reg_row(input logic [REG_W-1:0] regNum);
        return regNum[REG_W-1:BANK_W];
    endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gpu_rr_arbiter
// N-wide round-robin arbiter. The grant goes to the first valid input at or
// after the pointer, wrapping from N-1 to 0. After a grant the pointer moves
// to winner+1 (mod N); with no grant it holds.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (pointer -> 0)
//   i_valid  [N-1:0] request vector
//   o_grant  [N-1:0] one-hot grant (combinational), all zero if no request
// -----------------------------------------------------------------------------
module gpu_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_valid,
    output logic [N-1:0] o_grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_win;
    logic             w_any;
    int               w_idx;

    // Rotating priority scan starting at the pointer.
    always_comb begin
        o_grant = '0;
        w_win   = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_any && i_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = PTR_W'(w_idx);
            end
        end
        if (w_any) begin
            o_grant[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (int'(w_win) == N - 1) ? '0 : w_win + PTR_W'(1);
        end
    end

endmodule

// File: rtl/gpu_bank_arbiter.sv
// -----------------------------------------------------------------------------
// gpu_bank_arbiter
// Shares the single-ported register banks of a warp between NUM_REQ requesters.
// Each request's register number is split into bank/row; every bank runs its own
// round-robin arbiter; winners are registered into bank commands; read data
// returns to the winning requester three cycles after the handshake.
//
// Optional feature macro: GPU_BANK_ARB_WRITE_PRIORITY_EN
//   defined   - per bank, if any candidate is a write only writes compete.
//   undefined - reads and writes compete equally.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_write        per-requester request and direction
//   req_reg                    per-requester register number {row, bank}
//   req_wdata                  per-requester write data
//   req_ready                  combinational grant (handshake = valid & ready)
//   rsp_valid/rsp_data         read response per requester
//   bank_read/bank_write       registered per-bank strobes
//   bank_row/bank_wdata        registered per-bank row and write data
//   bank_rdata                 bank read data, one cycle after bank_read
//   conflict_cnt               saturating count of cycles with a stalled request
// -----------------------------------------------------------------------------
module gpu_bank_arbiter
    import gpu_reg_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*REG_W-1:0]      req_reg,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0]     rsp_data,
    output logic [NUM_BANKS-1:0]          bank_read,
    output logic [NUM_BANKS-1:0]          bank_write,
    output logic [NUM_BANKS*ROW_W-1:0]    bank_row,
    output logic [NUM_BANKS*DATA_W-1:0]   bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0]   bank_rdata,
    output logic [15:0]                   conflict_cnt
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] w_cand  [NUM_BANKS];
    logic [NUM_REQ-1:0] w_arbIn [NUM_BANKS];
    logic [NUM_REQ-1:0] w_grant [NUM_BANKS];
    logic [ID_W-1:0]    w_winId [NUM_BANKS];
    bank_cmd_t          w_cmd   [NUM_BANKS];
    bank_cmd_t          r_cmd   [NUM_BANKS];

    // Read tracking: stage 1 lines up with bank_read, stage 2 with bank_rdata.
    logic [NUM_BANKS-1:0] r_s1Vld;
    logic [NUM_BANKS-1:0] r_s2Vld;
    logic [ID_W-1:0]      r_s1Id [NUM_BANKS];
    logic [ID_W-1:0]      r_s2Id [NUM_BANKS];

    logic [NUM_REQ-1:0]   w_rspVld;
    logic [NUM_REQ-1:0]   r_rspVld;
    logic [DATA_W-1:0]    w_rspData [NUM_REQ];
    logic [DATA_W-1:0]    r_rspData [NUM_REQ];

    logic                 w_conflict;
    logic [15:0]          r_conflictCnt;

    // Per-bank candidate sets, optionally narrowed to writes only.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_cand[b] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                w_cand[b][i] = req_valid[i] &&
                               (reg_bank(req_reg[i*REG_W +: REG_W]) == BANK_W'(b));
            end
`ifdef GPU_BANK_ARB_WRITE_PRIORITY_EN
            w_arbIn[b] = (|(w_cand[b] & req_write)) ? (w_cand[b] & req_write) : w_cand[b];
`else
            w_arbIn[b] = w_cand[b];
`endif
        end
    end

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        gpu_rr_arbiter #(.N(NUM_REQ)) u_rrArb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_arbIn[gb]),
            .o_grant (w_grant[gb])
        );
    end

    // A requester targets one bank only, so OR-ing the bank grants never merges
    // two grants for the same requester.
    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_winId[b] = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[b][i]) begin
                    w_winId[b] = ID_W'(i);
                end
            end
            req_ready      = req_ready | w_grant[b];
            w_cmd[b].read  = (|w_grant[b]) & ~req_write[w_winId[b]];
            w_cmd[b].write = (|w_grant[b]) &  req_write[w_winId[b]];
            w_cmd[b].row   = reg_row(req_reg[int'(w_winId[b])*REG_W +: REG_W]);
            w_cmd[b].wdata = req_wdata[int'(w_winId[b])*DATA_W +: DATA_W];
        end
    end

    assign w_conflict = |(req_valid & ~req_ready);

    // Gather completed reads; at most one bank can return to a given requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rspVld[i]  = 1'b0;
            w_rspData[i] = r_rspData[i];
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_s2Vld[b] && (r_s2Id[b] == ID_W'(i))) begin
                    w_rspVld[i]  = 1'b1;
                    w_rspData[i] = bank_rdata[b*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Row/wdata only reload on a grant so idle banks see no toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_cmd[b]  <= '0;
                r_s1Id[b] <= '0;
                r_s2Id[b] <= '0;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rspData[i] <= '0;
            end
            r_s1Vld       <= '0;
            r_s2Vld       <= '0;
            r_rspVld      <= '0;
            r_conflictCnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_cmd[b].read  <= w_cmd[b].read;
                r_cmd[b].write <= w_cmd[b].write;
                if (w_cmd[b].read || w_cmd[b].write) begin
                    r_cmd[b].row   <= w_cmd[b].row;
                    r_cmd[b].wdata <= w_cmd[b].wdata;
                end
                r_s1Vld[b] <= w_cmd[b].read;
                r_s1Id[b]  <= w_winId[b];
                r_s2Vld[b] <= r_s1Vld[b];
                r_s2Id[b]  <= r_s1Id[b];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                r_rspData[i] <= w_rspData[i];
            end
            r_rspVld <= w_rspVld;
            if (w_conflict && (r_conflictCnt != 16'hFFFF)) begin
                r_conflictCnt <= r_conflictCnt + 16'd1;
            end
        end
    end

    always_comb begin
        bank_read  = '0;
        bank_write = '0;
        bank_row   = '0;
        bank_wdata = '0;
        rsp_data   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_read[b]                    = r_cmd[b].read;
            bank_write[b]                   = r_cmd[b].write;
            bank_row[b*ROW_W +: ROW_W]      = r_cmd[b].row;
            bank_wdata[b*DATA_W +: DATA_W]  = r_cmd[b].wdata;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data[i*DATA_W +: DATA_W] = r_rspData[i];
        end
    end

    assign rsp_valid    = r_rspVld;
    assign conflict_cnt = r_conflictCnt;

endmodule

// File: tb/tb_gpu_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gpu_bank_arbiter
// Self-checking bench for gpu_bank_arbiter with four requesters. A behavioural
// bank model answers the DUT's bank commands; a shadow copy of the register file
// plus a response queue predicts every read return. Directed sequences cover
// reset, latency, parallel issue, round-robin order and read-after-write; a
// vector table covers further grant patterns.
// Honours GPU_BANK_ARB_WRITE_PRIORITY_EN when the DUT is built with it.
// -----------------------------------------------------------------------------
module tb_gpu_bank_arbiter;

    localparam int NREQ = 4;
    localparam int NB   = 4;
    localparam int DW   = 64;
    localparam int RW   = 3;
    localparam int GW   = 5;

`ifdef GPU_BANK_ARB_WRITE_PRIORITY_EN
    localparam logic [3:0] WP_FIRST = 4'b1000;
    localparam logic [3:0] V4_READY = 4'b0100;
`else
    localparam logic [3:0] WP_FIRST = 4'b0001;
    localparam logic [3:0] V4_READY = 4'b0010;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ-1:0]     reqWrite;
    logic [NREQ*GW-1:0]  reqReg;
    logic [NREQ*DW-1:0]  reqWdata;
    logic [NREQ-1:0]     reqReady;
    logic [NREQ-1:0]     rspValid;
    logic [NREQ*DW-1:0]  rspData;
    logic [NB-1:0]       bankRead;
    logic [NB-1:0]       bankWrite;
    logic [NB*RW-1:0]    bankRow;
    logic [NB*DW-1:0]    bankWdata;
    logic [NB*DW-1:0]    bankRdata = '0;
    logic [15:0]         conflictCnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int expCnt = 0;

    // Backdoor preload of one bank word, applied by both bank model and shadow.
    logic             plEn = 1'b0;
    logic [1:0]       plBank = '0;
    logic [2:0]       plRow = '0;
    logic [DW-1:0]    plData = '0;

    logic [DW-1:0]    mem    [NB][8];
    logic [DW-1:0]    shadow [NB][8];
    logic             memInit = 1'b0;
    logic             shInit  = 1'b0;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } sb_t;
    sb_t sbq[$];
    int  mIdx;
    int  mB;
    int  mR;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  write;
        logic [19:0] regs;
        logic [3:0]  ready;
        logic        conf;
    } vec_t;
    vec_t vecs[8];

    gpu_bank_arbiter #(.NUM_REQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (reqValid),
        .req_write    (reqWrite),
        .req_reg      (reqReg),
        .req_wdata    (reqWdata),
        .req_ready    (reqReady),
        .rsp_valid    (rspValid),
        .rsp_data     (rspData),
        .bank_read    (bankRead),
        .bank_write   (bankWrite),
        .bank_row     (bankRow),
        .bank_wdata   (bankWdata),
        .bank_rdata   (bankRdata),
        .conflict_cnt (conflictCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] patt(input int b, input int r);
        return 64'hA5A5_0000_0000_0000 | (64'(b) << 4) | 64'(r);
    endfunction

    function automatic logic [NREQ*DW-1:0] wdPattern(input int k);
        logic [NREQ*DW-1:0] wd;
        wd = '0;
        for (int i = 0; i < NREQ; i++) begin
            wd[i*DW +: DW] = 64'hC0DE_0000_0000_0000 | (64'(k) << 8) | 64'(i);
        end
        return wd;
    endfunction

    function automatic logic [DW-1:0] rspWord(input int i);
        return rspData[i*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] w,
                                 input logic [19:0] regs, input logic [NREQ*DW-1:0] wd);
        reqValid = v;
        reqWrite = w;
        reqReg   = regs;
        reqWdata = wd;
    endtask

    task automatic clearStimulus();
        applyStimulus(4'b0000, 4'b0000, 20'd0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rst_n  = 1'b0;
        expCnt = 0;
        clearStimulus();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Behavioural register bank: write lands at the edge, read data follows
    // one cycle after the strobe.
    always @(posedge clk) begin
        if (!memInit) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 8; r++)
                    mem[b][r] <= patt(b, r);
            memInit <= 1'b1;
        end else begin
            if (plEn) mem[plBank][plRow] <= plData;
            for (int b = 0; b < NB; b++) begin
                if (bankWrite[b]) mem[b][bankRow[b*RW +: RW]] <= bankWdata[b*DW +: DW];
                if (bankRead[b])  bankRdata[b*DW +: DW] <= mem[b][bankRow[b*RW +: RW]];
            end
        end
    end

    // Scoreboard: compare responses due this cycle, then log new handshakes.
    always @(negedge clk) begin
        if (!shInit) begin
            for (int b = 0; b < NB; b++)
                for (int r = 0; r < 8; r++)
                    shadow[b][r] = patt(b, r);
            shInit = 1'b1;
        end
        if (!rst_n) begin
            sbq.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                mIdx = -1;
                for (int j = 0; j < sbq.size(); j++)
                    if (mIdx < 0 && sbq[j].id == i) mIdx = j;
                if (rspValid[i]) begin
                    if (mIdx < 0) begin
                        checkOutput($sformatf("rsp%0d_unexpected", i), 64'(rspValid[i]), 64'd0);
                    end else begin
                        checkOutput($sformatf("rsp%0d_cycle", i), 64'(cyc), 64'(sbq[mIdx].due));
                        checkOutput($sformatf("rsp%0d_data", i), rspWord(i), sbq[mIdx].data);
                        sbq.delete(mIdx);
                    end
                end else if (mIdx >= 0 && sbq[mIdx].due <= cyc) begin
                    checkOutput($sformatf("rsp%0d_missing", i), 64'(rspValid[i]), 64'd1);
                    sbq.delete(mIdx);
                end
            end
            if (plEn) shadow[plBank][plRow] = plData;
            for (int i = 0; i < NREQ; i++) begin
                if (reqValid[i] && reqReady[i]) begin
                    mB = int'(reqReg[i*GW +: 2]);
                    mR = int'(reqReg[i*GW+2 +: 3]);
                    if (reqWrite[i]) shadow[mB][mR] = reqWdata[i*DW +: DW];
                    else sbq.push_back('{i, shadow[mB][mR], cyc + 3});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // {valid, write, regs{r3,r2,r1,r0}, ready, conflict}
        vecs[0] = '{4'b1111, 4'b0000, {5'd9,  5'd5,  5'd12, 5'd8}, 4'b0110, 1'b1};
        vecs[1] = '{4'b1111, 4'b0000, {5'd9,  5'd5,  5'd12, 5'd8}, 4'b1001, 1'b1};
        vecs[2] = '{4'b1111, 4'b1111, {5'd31, 5'd10, 5'd6,  5'd2}, 4'b1001, 1'b1};
        vecs[3] = '{4'b0110, 4'b0100, {5'd0,  5'd6,  5'd2,  5'd0}, V4_READY, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, {5'd0,  5'd0,  5'd0,  5'd0}, 4'b0000, 1'b0};
        vecs[5] = '{4'b1000, 4'b0000, {5'd27, 5'd0,  5'd0,  5'd0}, 4'b1000, 1'b0};
        vecs[6] = '{4'b0011, 4'b0001, {5'd0,  5'd0,  5'd9,  5'd1}, 4'b0001, 1'b1};
        vecs[7] = '{4'b0101, 4'b0000, {5'd0,  5'd3,  5'd0,  5'd3}, 4'b0001, 1'b1};

        rst_n = 1'b0;
        clearStimulus();
        #1;
        checkOutput("rst_bank_read",  64'(bankRead),  64'd0);
        checkOutput("rst_bank_write", 64'(bankWrite), 64'd0);
        checkOutput("rst_bank_row",   64'(bankRow),   64'd0);
        checkOutput("rst_bank_wdata", 64'(bankWdata != '0), 64'd0);
        checkOutput("rst_rsp_valid",  64'(rspValid),  64'd0);
        checkOutput("rst_rsp_data",   64'(rspData != '0), 64'd0);
        checkOutput("rst_conflict",   64'(conflictCnt), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset in the middle of a read: the response must never appear.
        tick();
        applyStimulus(4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd5}, '0);
        @(negedge clk);
        checkOutput("rstmid_ready", 64'(reqReady), 64'd1);
        tick();
        clearStimulus();
        rst_n  = 1'b0;
        expCnt = 0;
        #1;
        checkOutput("rstmid_bank_read", 64'(bankRead), 64'd0);
        checkOutput("rstmid_bank_row",  64'(bankRow),  64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rstmid_no_rsp", 64'(rspValid), 64'd0);
        end
        checkOutput("rstmid_cnt", 64'(conflictCnt), 64'd0);

        // All four requesters on reg 4: grants rotate 0,1,2,3.
        for (int k = 0; k < 4; k++) begin
            tick();
            applyStimulus(4'b1111 << k, 4'b0000, {4{5'd4}}, '0);
            @(negedge clk);
            checkOutput($sformatf("rr%0d_ready", k), 64'(reqReady), 64'(4'b0001 << k));
            checkOutput($sformatf("rr%0d_cnt", k), 64'(conflictCnt), 64'(expCnt));
            if (((4'b1111 << k) & ~(4'b0001 << k)) != 4'b0000) expCnt++;
        end
        tick();
        clearStimulus();
        @(negedge clk);
        checkOutput("rr_cnt_final", 64'(conflictCnt), 64'd3);

        // Read and write collide on bank 0 with pointer at 0.
        tick();
        applyStimulus(4'b1001, 4'b1000, 20'd0, {64'h5555_AAAA_0000_0007, 192'd0});
        @(negedge clk);
        checkOutput("wp_first_ready", 64'(reqReady), 64'(WP_FIRST));
        expCnt++;
        tick();
        applyStimulus(4'b1001 & ~WP_FIRST, 4'b1000, 20'd0, {64'h5555_AAAA_0000_0007, 192'd0});
        @(negedge clk);
        checkOutput("wp_second_ready", 64'(reqReady), 64'(4'b1001 & ~WP_FIRST));
        tick();
        clearStimulus();
        @(negedge clk);
        checkOutput("wp_cnt", 64'(conflictCnt), 64'(expCnt));
        repeat (5) tick();

        doReset();

        // Single read with preloaded data: command at t+1, response at t+3.
        tick();
        plEn = 1'b1; plBank = 2'd2; plRow = 3'd3; plData = 64'hDEAD_BEEF;
        tick();
        plEn = 1'b0;
        applyStimulus(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd14, 5'd0}, '0);
        @(negedge clk);
        checkOutput("sr_ready", 64'(reqReady), 64'b0010);
        tick();
        clearStimulus();
        @(negedge clk);
        checkOutput("sr_bank_read", 64'(bankRead), 64'b0100);
        checkOutput("sr_bank_row",  64'(bankRow[2*RW +: RW]), 64'd3);
        tick();
        @(negedge clk);
        checkOutput("sr_rsp_early", 64'(rspValid), 64'd0);
        tick();
        @(negedge clk);
        checkOutput("sr_rsp_valid", 64'(rspValid), 64'b0010);
        checkOutput("sr_rsp_data",  rspWord(1), 64'hDEAD_BEEF);

        // Four requesters to four banks: no conflict.
        tick();
        applyStimulus(4'b1111, 4'b0000, {5'd3, 5'd2, 5'd1, 5'd0}, '0);
        @(negedge clk);
        checkOutput("par_ready", 64'(reqReady), 64'b1111);
        tick();
        clearStimulus();
        @(negedge clk);
        checkOutput("par_bank_read", 64'(bankRead), 64'b1111);
        checkOutput("par_cnt", 64'(conflictCnt), 64'(expCnt));
        tick();
        tick();
        @(negedge clk);
        checkOutput("par_rsp_valid", 64'(rspValid), 64'b1111);

        // Write reg 7 then read it on the next cycle.
        tick();
        applyStimulus(4'b0100, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, {64'd0, 64'h1234, 128'd0});
        @(negedge clk);
        checkOutput("raw_wr_ready", 64'(reqReady), 64'b0100);
        tick();
        applyStimulus(4'b0001, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd7}, '0);
        @(negedge clk);
        checkOutput("raw_rd_ready",   64'(reqReady), 64'b0001);
        checkOutput("raw_bank_write", 64'(bankWrite), 64'b1000);
        checkOutput("raw_bank_row",   64'(bankRow[3*RW +: RW]), 64'd1);
        checkOutput("raw_bank_wdata", bankWdata[3*DW +: DW], 64'h1234);
        tick();
        clearStimulus();
        tick();
        tick();
        @(negedge clk);
        checkOutput("raw_rsp_valid", 64'(rspValid), 64'b0001);
        checkOutput("raw_rsp_data",  rspWord(0), 64'h1234);

        // Table of grant patterns, applied back to back.
        for (int k = 0; k < 8; k++) begin
            tick();
            applyStimulus(vecs[k].valid, vecs[k].write, vecs[k].regs, wdPattern(k));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ready", k), 64'(reqReady), 64'(vecs[k].ready));
            checkOutput($sformatf("vec%0d_cnt", k), 64'(conflictCnt), 64'(expCnt));
            if (vecs[k].conf) expCnt++;
        end
        tick();
        clearStimulus();
        @(negedge clk);
        checkOutput("vec_cnt_final", 64'(conflictCnt), 64'(expCnt));
        repeat (5) tick();
        @(negedge clk);
        checkOutput("sb_drained", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
